ahb_write_post_buffer: RTL and testbench

Posted-write buffer between the Hazard3 AHB-lite fabric and the SDRAM-backed memory slave. Upstream writes complete in one data-phase cycle while a FIFO slot is free; entries drain to the memory slave one transfer at a time. Reads wait until every buffered write has drained, unless address-checked bypass is compiled in. Downstream sees at most one outstanding transfer, with no address phase overlapping a data phase.

---
 rtl/ahb_write_post_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_ahb_write_post_buffer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_write_post_buffer.sv
// ahb_write_post_buffer
// Posted-write buffer between the AHB-lite fabric and the SDRAM memory slave.
// Upstream writes retire in one data-phase cycle while a FIFO slot is free.
// Buffered entries drain downstream one transfer at a time, and a read waits
// until every buffered write has drained.
// Optional feature macro: WPB_READ_BYPASS_EN. When defined, a read may overtake
// buffered writes whose word address does not match the read address.
module ahb_write_post_buffer #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [W_ADDR-1:0]        s_haddr,
  input  logic                     s_hwrite,
  input  logic [1:0]               s_htrans,
  input  logic [2:0]               s_hsize,
  input  logic [W_DATA-1:0]        s_hwdata,
  input  logic                     s_hready,
  output logic                     s_hready_resp,
  output logic                     s_hresp,
  output logic [W_DATA-1:0]        s_hrdata,
  output logic [W_ADDR-1:0]        m_haddr,
  output logic                     m_hwrite,
  output logic [1:0]               m_htrans,
  output logic [2:0]               m_hsize,
  output logic [W_DATA-1:0]        m_hwdata,
  output logic                     m_hready,
  input  logic                     m_hready_resp,
  input  logic                     m_hresp,
  input  logic [W_DATA-1:0]        m_hrdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     bus_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_L = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, WA, WD, RA, RD, RRESP} state_t;
  state_t state;

  logic [W_ADDR-1:0] fifo_addr [DEPTH];
  logic [2:0]        fifo_size [DEPTH];
  logic [W_DATA-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic              dp_valid;
  logic              dp_write;
  logic [W_ADDR-1:0] dp_addr;
  logic [2:0]        dp_size;
  logic              rd_wait;

  logic              full;
  logic              push;
  logic              pop;
  logic              aphase_rd;
  logic              rd_req;
  logic [W_ADDR-1:0] rd_addr;
  logic [2:0]        rd_size;
  logic              rd_ok;
  logic              launch;
  logic              unused_bits;

  assign full      = (level == DEPTH_L);
  assign push      = dp_valid && dp_write && !full;
  assign pop       = (state == WD) && m_hready_resp;
  assign aphase_rd = s_htrans[1] && s_hready && !s_hwrite;
  assign rd_req    = aphase_rd || rd_wait;
  assign rd_addr   = aphase_rd ? s_haddr : dp_addr;
  assign rd_size   = aphase_rd ? s_hsize : dp_size;
  assign launch    = (state == IDLE) && rd_req && rd_ok;

  assign s_hresp       = 1'b0;
  assign s_hready_resp = !dp_valid || (dp_write ? !full : (state == RRESP));
  assign unused_bits   = s_htrans[0];

`ifdef WPB_READ_BYPASS_EN
  logic hit;

  // Word-address match of the read against every valid entry and the entry being pushed now
  always_comb begin
    hit = push && (dp_addr[W_ADDR-1:2] == rd_addr[W_ADDR-1:2]);
    for (int k = 0; k < DEPTH; k++) begin
      if (((PW+1)'(k) < level) &&
          (fifo_addr[rd_ptr + PW'(k)][W_ADDR-1:2] == rd_addr[W_ADDR-1:2]))
        hit = 1'b1;
    end
  end

  assign rd_ok = !hit;
`else
  assign rd_ok = (level == '0) && !push;
`endif

  // Capture the upstream address phase whenever the bus is ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      dp_size  <= '0;
    end else if (s_hready) begin
      dp_valid <= s_htrans[1];
      dp_write <= s_hwrite;
      dp_addr  <= s_haddr;
      dp_size  <= s_hsize;
    end
  end

  // Remember a read that could not be launched in its own address phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rd_wait <= 1'b0;
    else if (launch)
      rd_wait <= 1'b0;
    else if (aphase_rd)
      rd_wait <= 1'b1;
  end

  // FIFO storage needs no reset; validity is carried by the pointers and level
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= dp_addr;
      fifo_size[wr_ptr] <= dp_size;
      fifo_data[wr_ptr] <= s_hwdata;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keep level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        level <= level + (PW+1)'(1);
      else if (pop && !push)
        level <= level - (PW+1)'(1);
    end
  end

  // Downstream sequencer: one transfer at a time, reads take priority when eligible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_haddr  <= '0;
      m_hwrite <= 1'b0;
      m_htrans <= 2'b00;
      m_hsize  <= '0;
      m_hwdata <= '0;
      m_hready <= 1'b0;
      s_hrdata <= '0;
      bus_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (launch) begin
            state    <= RA;
            m_htrans <= 2'b10;
            m_hwrite <= 1'b0;
            m_hready <= 1'b1;
            m_haddr  <= rd_addr;
            m_hsize  <= rd_size;
          end else if (level != '0) begin
            state    <= WA;
            m_htrans <= 2'b10;
            m_hwrite <= 1'b1;
            m_hready <= 1'b1;
            m_haddr  <= fifo_addr[rd_ptr];
            m_hsize  <= fifo_size[rd_ptr];
          end
        end
        WA: begin
          state    <= WD;
          m_htrans <= 2'b00;
          m_hready <= 1'b0;
          m_hwdata <= fifo_data[rd_ptr];
        end
        WD: begin
          if (m_hready_resp) begin
            state <= IDLE;
            if (m_hresp)
              bus_err <= 1'b1;
          end
        end
        RA: begin
          state    <= RD;
          m_htrans <= 2'b00;
          m_hready <= 1'b0;
        end
        RD: begin
          if (m_hready_resp) begin
            state    <= RRESP;
            s_hrdata <= m_hrdata;
            if (m_hresp)
              bus_err <= 1'b1;
          end
        end
        RRESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_write_post_buffer.sv
// tb_ahb_write_post_buffer
// Randomised and directed traffic from a pipelined AHB master model into the
// post buffer, with a memory slave model downstream. Expected downstream writes
// and upstream read data come from a program-order memory model; a monitor and
// the slave model compare against queued expectations.
// Optional feature macro: WPB_READ_BYPASS_EN (enables the overtaking scenario).
module tb_ahb_write_post_buffer;

  localparam int DEPTH = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    int          seq;
  } txn_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_haddr;
  logic        s_hwrite;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize;
  logic [31:0] s_hwdata;
  logic        s_hready_resp;
  logic        s_hresp;
  logic [31:0] s_hrdata;
  logic [31:0] m_haddr;
  logic        m_hwrite;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic        m_hready;
  logic        m_hready_resp;
  logic        m_hresp;
  logic [31:0] m_hrdata;
  logic [2:0]  level;
  logic        bus_err;

  int tests_run = 0;
  int tests_failed = 0;

  txn_t stimq[$];
  txn_t exp_wr[$];
  txn_t exp_rd[$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] dmem [int unsigned];

  txn_t ap;
  bit   ap_has = 0;
  bit   dp_has = 0;
  int   seq_ctr = 0;
  bit   hready_seen = 1;

  int   pushes = 0;
  int   pops = 0;
  int   stall_cycles = 0;
  int   rd_len = 0;
  int   last_rd_len = 0;
  int   pops_at_rd = 0;
  bit   mon_wr = 0;
  bit   mon_rd = 0;

  int   wait_cfg = 0;
  bit   err_arm = 0;
  bit   s_dph = 0;
  bit   s_wr = 0;
  int   s_wcnt = 0;
  logic [31:0] s_addr = '0;
  txn_t s_exp;
  int   ds_aphases = 0;

  ahb_write_post_buffer #(.W_ADDR(32), .W_DATA(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans), .s_hsize(s_hsize),
    .s_hwdata(s_hwdata), .s_hready(s_hready_resp),
    .s_hready_resp(s_hready_resp), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_htrans(m_htrans), .m_hsize(m_hsize),
    .m_hwdata(m_hwdata), .m_hready(m_hready),
    .m_hready_resp(m_hready_resp), .m_hresp(m_hresp), .m_hrdata(m_hrdata),
    .level(level), .bus_err(bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int kind, input logic [31:0] addr, input logic [31:0] data, input logic [2:0] size);
    txn_t t;
    t.kind = kind;
    t.addr = addr;
    t.data = data;
    t.size = size;
    t.seq  = 0;
    stimq.push_back(t);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_s_hready_resp"}, s_hready_resp, 1);
    checkOutput({tag, "_s_hresp"}, s_hresp, 0);
    checkOutput({tag, "_s_hrdata"}, s_hrdata, 0);
    checkOutput({tag, "_m_htrans"}, m_htrans, 0);
    checkOutput({tag, "_m_hwrite"}, m_hwrite, 0);
    checkOutput({tag, "_m_hready"}, m_hready, 0);
    checkOutput({tag, "_m_haddr"}, m_haddr, 0);
    checkOutput({tag, "_m_hsize"}, m_hsize, 0);
    checkOutput({tag, "_m_hwdata"}, m_hwdata, 0);
    checkOutput({tag, "_level"}, level, 0);
    checkOutput({tag, "_bus_err"}, bus_err, 0);
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((stimq.size() != 0 || ap_has || dp_has || level != 0 || s_dph ||
            exp_wr.size() != 0 || exp_rd.size() != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (n >= budget) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
    repeat (2) @(posedge clk);
  endtask

  // Upstream pipelined master: next address phase overlaps current data phase
  initial begin
    s_htrans = 2'b00;
    s_haddr  = '0;
    s_hwrite = 1'b0;
    s_hsize  = 3'b000;
    s_hwdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ap_has   = 0;
        dp_has   = 0;
        s_htrans = 2'b00;
        s_hwrite = 1'b0;
      end else if (hready_seen) begin
        dp_has = ap_has;
        if (ap_has && ap.kind == 1)
          s_hwdata = ap.data;
        ap_has   = 0;
        s_htrans = 2'b00;
        if (stimq.size() > 0) begin
          ap = stimq.pop_front();
          if (ap.kind != 0) begin
            ap.seq = seq_ctr;
            seq_ctr++;
            ap_has   = 1;
            s_haddr  = ap.addr;
            s_hwrite = (ap.kind == 1);
            s_hsize  = ap.size;
            s_htrans = 2'b10;
            if (ap.kind == 1) begin
              exp_wr.push_back(ap);
              ref_mem[ap.addr] = ap.data;
            end else begin
              ap.data = ref_mem.exists(ap.addr) ? ref_mem[ap.addr] : default_word(ap.addr);
              exp_rd.push_back(ap);
            end
          end
        end
      end
    end
  end

  // Upstream monitor: occupancy model, write readiness, read data and latency
  initial begin
    forever begin
      @(negedge clk);
      hready_seen = s_hready_resp;
      if (!rst_n) begin
        mon_wr = 0;
        mon_rd = 0;
        pushes = 0;
      end else begin
        checkOutput("level", 32'(level), 32'(pushes - pops));
        if (mon_wr) begin
          checkOutput("wr_ready", s_hready_resp, ((pushes - pops) < DEPTH) ? 1 : 0);
          if (!s_hready_resp)
            stall_cycles++;
        end
        if (mon_rd) begin
          rd_len++;
          if (s_hready_resp) begin
            last_rd_len = rd_len;
            pops_at_rd  = pops;
            if (exp_rd.size() == 0) begin
              tests_run++;
              tests_failed++;
              $display("[TB] FAIL unexpected_read: data 0x%08h returned, required none pending", s_hrdata);
            end else begin
              checkOutput("rdata", s_hrdata, exp_rd.pop_front().data);
            end
          end
        end
        if (s_hready_resp) begin
          if (mon_wr)
            pushes++;
          mon_wr = s_htrans[1] && s_hwrite;
          mon_rd = s_htrans[1] && !s_hwrite;
          rd_len = 0;
        end
      end
    end
  end

  // Downstream memory slave with configurable wait states and error injection
  initial begin
    m_hready_resp = 1'b0;
    m_hresp       = 1'b0;
    m_hrdata      = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        s_dph = 0;
        m_hready_resp = 1'b0;
        m_hresp = 1'b0;
        pops = 0;
        ds_aphases = 0;
      end else begin
        m_hready_resp = 1'b0;
        m_hresp = 1'b0;
        if (s_dph) begin
          checkOutput("dphase_htrans_idle", m_htrans, 0);
          if (s_wcnt == 0) begin
            m_hready_resp = 1'b1;
            if (s_wr) begin
              m_hresp = err_arm;
              err_arm = 0;
              checkOutput("ds_wdata", m_hwdata, s_exp.data);
              dmem[s_addr] = m_hwdata;
              pops++;
            end else begin
              m_hrdata = dmem.exists(s_addr) ? dmem[s_addr] : default_word(s_addr);
            end
            s_dph = 0;
          end else begin
            s_wcnt--;
          end
        end
        if (m_htrans == 2'b10) begin
          ds_aphases++;
          checkOutput("ds_single_outstanding", s_dph, 0);
          checkOutput("ds_aphase_hready", m_hready, 1);
          s_dph  = 1;
          s_addr = m_haddr;
          s_wr   = m_hwrite;
          s_wcnt = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
          if (m_hwrite) begin
            if (exp_wr.size() == 0) begin
              tests_run++;
              tests_failed++;
              $display("[TB] FAIL unexpected_ds_write: addr 0x%08h, required none", m_haddr);
            end else begin
              s_exp = exp_wr.pop_front();
              checkOutput("ds_waddr", m_haddr, s_exp.addr);
              checkOutput("ds_hsize", m_hsize, s_exp.size);
            end
          end else if (exp_rd.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_ds_read: addr 0x%08h, required none", m_haddr);
          end else begin
            checkOutput("ds_raddr", m_haddr, exp_rd[0].addr);
`ifndef WPB_READ_BYPASS_EN
            checkOutput("read_after_writes",
                        (exp_wr.size() == 0 || exp_wr[0].seq > exp_rd[0].seq) ? 1 : 0, 1);
`endif
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkResetValues("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    applyStimulus(1, 32'h100, 32'hDEADBEEF, 3'b010);
    waitIdle(200);

    wait_cfg = 10;
    stall_cycles = 0;
    for (int i = 0; i < DEPTH + 1; i++)
      applyStimulus(1, 32'h1000 + 32'(4 * i), $urandom, 3'b010);
    waitIdle(1000);
    checkOutput("full_stall_seen", (stall_cycles > 0) ? 1 : 0, 1);
    wait_cfg = 0;

    applyStimulus(1, 32'h200, 32'h12345678, 3'b010);
    applyStimulus(2, 32'h200, 32'h0, 3'b010);
    waitIdle(200);

    applyStimulus(2, 32'h100, 32'h0, 3'b010);
    waitIdle(200);
    checkOutput("read_latency", 32'(last_rd_len), 3);

    err_arm = 1;
    applyStimulus(1, 32'h500, 32'hA5A5_5A5A, 3'b010);
    waitIdle(200);
    checkOutput("bus_err_set", bus_err, 1);

    wait_cfg = -1;
    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = int'($urandom_range(0, 9));
      applyStimulus((sel < 5) ? 1 : ((sel < 8) ? 2 : 0),
                    32'h40 + 32'(4 * $urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 2)));
    end
    waitIdle(5000);
    checkOutput("bus_err_sticky", bus_err, 1);

`ifdef WPB_READ_BYPASS_EN
    wait_cfg = 10;
    applyStimulus(1, 32'h300, 32'h0000_0300, 3'b010);
    applyStimulus(1, 32'h304, 32'h0000_0304, 3'b010);
    applyStimulus(2, 32'h400, 32'h0, 3'b010);
    waitIdle(1000);
    checkOutput("bypass_read_overtakes", (pops_at_rd < 2) ? 1 : 0, 1);
`endif

    wait_cfg = 10;
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 32'h2000 + 32'(4 * i), $urandom, 3'b010);
    begin
      int n = 0;
      while (!(level == 3 && s_dph && s_wr) && n < 300) begin
        @(posedge clk);
        #2;
        n++;
      end
      if (n >= 300) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL reset_setup: level %0d never reached 3 during a write data phase", level);
      end
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    stimq.delete();
    exp_wr.delete();
    exp_rd.delete();
    repeat (2) @(posedge clk);
    #2;
    checkResetValues("midreset");
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #2;
    checkOutput("no_ds_after_reset", 32'(ds_aphases), 0);
    checkOutput("level_after_reset", level, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
